hamming_enc_stage: RTL
======================

HAMMING_ENC_STAGE -- requirements
Module: hamming_enc_stage

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter PW, default 4, parity width; TW = DW+PW SHALL satisfy TW < 2**PW.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  upstream beat valid.
REQ-006 o_ready  output  1  stage can accept a beat.
REQ-007 i_data  input  DW  upstream payload.
REQ-008 o_valid  output  1  encoded beat valid.
REQ-009 i_ready  input  1  downstream (memory or hamming decoder path) accepts the beat.
REQ-010 o_enc_data  output  DW  data field of the codeword, possibly with one injected flip.
REQ-011 o_parity  output  PW  parity field of the codeword, possibly with one injected flip.
REQ-012 i_inj_en  input  1  one-cycle request to arm a single-bit error injection.
REQ-013 i_inj_pos  input  PW  Hamming position (1..TW) to corrupt; sampled when i_inj_en=1.
REQ-014 o_inj_armed  output  1  injection armed, not yet applied.
REQ-015 o_inj_done  output  1  one-cycle pulse when the injected beat is accepted upstream.
REQ-016 o_beat_cnt  output  16  saturating count of beats delivered downstream.

Function
REQ-017 Codeword positions 1..TW; power-of-two positions hold parity, the remaining positions hold data bits 0..DW-1 in ascending order.
REQ-018 o_parity[i] SHALL equal the XOR of all data bits whose position has bit i set, so a clean codeword gives a zero syndrome at the decoder.
REQ-019 Upstream accept = i_valid & o_ready; downstream transfer = o_valid & i_ready.
REQ-020 Latency SHALL be 1 cycle: a beat accepted in cycle N appears on the outputs in cycle N+1 if the output register is free.
REQ-021 Sustained throughput SHALL be 1 beat/cycle with i_ready held high.
REQ-022 Buffering is a 2-entry skid (output register plus skid register), with FSM states EMPTY, ONE and TWO.
REQ-023 Transitions:
- EMPTY -> ONE on accept.
- ONE -> TWO on accept without transfer.
- ONE -> EMPTY on transfer without accept.
- ONE stays in ONE on simultaneous accept and transfer.
- TWO -> ONE on transfer, with the skid entry moving to the output register.
REQ-024 o_ready SHALL be registered and equal 1 exactly when the state is not TWO.
REQ-025 o_valid SHALL be 1 in ONE and TWO.
REQ-026 While o_valid=1 and i_ready=0, o_enc_data and o_parity SHALL hold stable.
REQ-027 Order SHALL be preserved and no beat dropped or duplicated.
REQ-028 Parity is computed at accept and stored with the beat.
REQ-029 i_inj_en with i_inj_pos in 1..TW SHALL set armed and latch the position.
REQ-030 i_inj_en with i_inj_pos of 0 or >TW SHALL be ignored.
REQ-031 A new valid i_inj_en while armed SHALL overwrite the latched position.
REQ-032 The first beat accepted while armed SHALL be corrupted:
- the bit at the latched position is flipped (data bit if non-power-of-two, parity bit log2(pos) otherwise);
- armed clears;
- o_inj_done pulses in the cycle after that accept.
REQ-033 If i_inj_en and an accept occur in the same cycle, that beat SHALL NOT be corrupted and the new arming SHALL take effect.
REQ-034 o_beat_cnt SHALL increment on each transfer and saturate at 0xFFFF.

Reset
REQ-035 Assertion of i_rstn=0 SHALL immediately clear state to EMPTY, with o_valid=0, o_ready=0, o_enc_data=0, o_parity=0, armed=0, o_inj_done=0, o_beat_cnt=0.
REQ-036 o_ready SHALL rise in the first clock after deassertion.
REQ-037 Beats in flight at reset SHALL be discarded.

Structure
REQ-038 A shared package hamming_ecc_pkg SHALL hold the position helpers (is-power-of-two, data-index-to-position table) and the TW derivation, reused by the decoder.
REQ-039 Parity generation SHALL be a combinational sub-module hamming_enc (data in, parity out).
REQ-040 The skid FSM, injection logic and counter SHALL reside in hamming_enc_stage.

Verification
REQ-041 Encode check: i_data=0xFF accepted -> o_enc_data=0xFF, o_parity=0x3 one cycle later.
REQ-042 Data injection: i_inj_en, pos=3, then data 0x00 -> o_enc_data=0x01, o_parity=0x0, o_inj_done pulse; the downstream decoder reports syndrome 3 and corrected data 0x00.
REQ-043 Parity injection: pos=4, data 0x00 -> o_enc_data=0x00, o_parity=0x4; invalid pos=13 -> o_inj_armed stays 0.
REQ-044 Backpressure: 10 back-to-back beats with i_ready low for cycles 3-6 -> o_ready low only in TWO, all 10 beats in order, o_beat_cnt=10.
REQ-045 Reset mid-stream in state TWO -> outputs zero asynchronously, no stale beat delivered after release.
REQ-046 Random traffic with a scoreboard and a decoder model: zero syndrome on every uninjected beat.

Source files
------------

// File: rtl/hamming_ecc_pkg.sv
// Shared Hamming ECC helpers for the encoder stage and the matching decoder.
// Codeword positions run 1..TW. Parity bits sit at power-of-two positions.
// Data bits fill the remaining positions in ascending order.
// Contents:
//   skid_state_e - buffer occupancy states of the encoder output skid.
//   calc_tw      - codeword width from data and parity widths.
//   is_pow2      - true for a parity position.
//   data_pos     - codeword position of data bit idx.
//   parity_mask  - data bits covered by parity bit pbit.
package hamming_ecc_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic int calc_tw(input int dw, input int pw);
    return dw + pw;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // 64 data bits need 7 parity slots, so 2*MAX_DW positions always suffice.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p <= 2 * MAX_DW; p++) begin
      if ((pos == 0) && !is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [MAX_DW-1:0] parity_mask(input int dw, input int pbit);
    logic [MAX_DW-1:0] m;
    int pos;
    m = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < dw) begin
        pos = data_pos(i);
        m[i] = ((pos >> pbit) & 1) != 0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_enc_stage_if.sv
// Handshake and injection bundle of the Hamming encoder stage.
// Signal names keep the stage's point of view: i_* flows into the stage, o_* out of it.
//   i_valid / o_ready / i_data                 upstream beat handshake and payload
//   o_valid / i_ready / o_enc_data / o_parity  downstream codeword handshake
//   i_inj_en / i_inj_pos                       single-bit error injection request
//   o_inj_armed / o_inj_done                   injection status
//   o_beat_cnt                                 saturating count of delivered beats
// slave  - the stage itself.
// master - the environment that drives the stage.
interface hamming_enc_stage_if #(
  parameter int DW = 8,
  parameter int PW = 4
);
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_enc_data;
  logic [PW-1:0] o_parity;
  logic          i_inj_en;
  logic [PW-1:0] i_inj_pos;
  logic          o_inj_armed;
  logic          o_inj_done;
  logic [15:0]   o_beat_cnt;

  modport slave (
    input  i_valid, i_data, i_ready, i_inj_en, i_inj_pos,
    output o_ready, o_valid, o_enc_data, o_parity, o_inj_armed, o_inj_done, o_beat_cnt
  );

  modport master (
    output i_valid, i_data, i_ready, i_inj_en, i_inj_pos,
    input  o_ready, o_valid, o_enc_data, o_parity, o_inj_armed, o_inj_done, o_beat_cnt
  );
endinterface

// File: rtl/hamming_enc.sv
// Combinational Hamming parity generator.
// Ports:
//   data   [DW-1:0] payload placed on non-power-of-two codeword positions
//   parity [PW-1:0] parity[j] is the XOR of the data bits whose position has bit j set
module hamming_enc
  import hamming_ecc_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input  logic [DW-1:0] data,
  output logic [PW-1:0] parity
);

  for (genvar j = 0; j < PW; j++) begin : g_par
    localparam logic [MAX_DW-1:0] MASK = parity_mask(DW, j);
    assign parity[j] = ^(data & MASK[DW-1:0]);
  end

endmodule

// File: rtl/hamming_enc_stage.sv
// Hamming encoder stage with a 2-entry skid buffer and single-bit error injection.
// Each accepted beat is encoded on the way in and stored with its parity.
// A beat accepted while injection is armed has one codeword bit flipped before it is stored.
// Ports:
//   i_clk   rising-edge clock
//   i_rstn  asynchronous active-low reset
//   bus     hamming_enc_stage_if.slave: upstream/downstream handshakes, injection control,
//           and the delivered-beat counter
module hamming_enc_stage
  import hamming_ecc_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input logic                i_clk,
  input logic                i_rstn,
  hamming_enc_stage_if.slave bus
);

  localparam int            TW   = calc_tw(DW, PW);
  localparam logic [PW-1:0] TW_P = PW'(TW);

  if (TW >= (1 << PW)) begin : g_bad_width
    $error("hamming_enc_stage: DW+PW must be below 2**PW");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  skid_state_e   state_q, state_d;
  logic          ready_q;
  logic          vld_p1;
  logic          accept, xfer;
  logic          load_out, load_skid, skid_to_out;

  logic [PW-1:0] par_p0;
  logic [DW-1:0] beat_data_p0;
  logic [PW-1:0] beat_par_p0;
  logic [DW-1:0] data_flip;
  logic [PW-1:0] par_flip;
  logic          inj_req, inj_hit;

  logic          armed_q;
  logic [PW-1:0] inj_pos_q;
  logic          inj_done_q;
  logic [15:0]   beat_cnt_q;

  logic [DW-1:0] out_data_p1, skid_data_p1;
  logic [PW-1:0] out_par_p1, skid_par_p1;

  assign vld_p1 = (state_q != SKID_EMPTY);
  assign accept = bus.i_valid & ready_q;
  assign xfer   = vld_p1 & bus.i_ready;

  // Stage p0: encode the incoming beat and apply any armed injection
  hamming_enc #(.DW(DW), .PW(PW)) u_enc (
    .data   (bus.i_data),
    .parity (par_p0)
  );

  // A valid request in the same cycle as an accept re-arms instead of corrupting.
  assign inj_req = bus.i_inj_en & (bus.i_inj_pos != '0) & (bus.i_inj_pos <= TW_P);
  assign inj_hit = accept & armed_q & ~inj_req;

  for (genvar i = 0; i < DW; i++) begin : g_dflip
    localparam int DPOS = data_pos(i);
    assign data_flip[i] = (inj_pos_q == PW'(DPOS));
  end

  for (genvar j = 0; j < PW; j++) begin : g_pflip
    assign par_flip[j] = (inj_pos_q == PW'(1 << j));
  end

  assign beat_data_p0 = bus.i_data ^ (data_flip & {DW{inj_hit}});
  assign beat_par_p0  = par_p0 ^ (par_flip & {PW{inj_hit}});

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d  = SKID_ONE;
          load_out = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && !xfer) begin
          state_d   = SKID_TWO;
          load_skid = 1'b1;
        end else if (!accept && xfer) begin
          state_d = SKID_EMPTY;
        end else if (accept && xfer) begin
          load_out = 1'b1;
        end
      end
      SKID_TWO: begin
        if (xfer) begin
          state_d     = SKID_ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_TWO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      armed_q    <= 1'b0;
      inj_pos_q  <= '0;
      inj_done_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inj_done_q <= inj_hit;
      if (inj_req) begin
        armed_q   <= 1'b1;
        inj_pos_q <= bus.i_inj_pos;
      end else if (inj_hit) begin
        armed_q <= 1'b0;
      end
      if (xfer) beat_cnt_q <= sat_inc(beat_cnt_q);
    end
  end

  // Stage p1: output register plus skid register
  // The output register is cleared by reset so the codeword outputs read zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_data_p1 <= '0;
      out_par_p1  <= '0;
    end else if (load_out) begin
      out_data_p1 <= beat_data_p0;
      out_par_p1  <= beat_par_p0;
    end else if (skid_to_out) begin
      out_data_p1 <= skid_data_p1;
      out_par_p1  <= skid_par_p1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_skid) begin
      skid_data_p1 <= beat_data_p0;
      skid_par_p1  <= beat_par_p0;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = vld_p1;
  assign bus.o_enc_data  = out_data_p1;
  assign bus.o_parity    = out_par_p1;
  assign bus.o_inj_armed = armed_q;
  assign bus.o_inj_done  = inj_done_q;
  assign bus.o_beat_cnt  = beat_cnt_q;

endmodule
